// File: rtl/mem_subblock_wrapper_core_if.sv
// Simplified AXI4-Lite link between the self-test master and the RAM slave.
// A beat transfers in any cycle where valid and ready are both high; valid, once raised, holds with a stable payload until accepted.
interface mem_subblock_wrapper_core_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport monitor (
    input awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_subblock_wrapper_core.sv
// Memory self-test: a pattern-writing/reading master and a single-port RAM slave joined by an AXI4-Lite link.
// The master writes every word, reads every word back, and reports mismatches.

module mem_subblock_master #(
  parameter int          DEPTH      = 256,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'hA5A5A5A5,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic                    aclk,
  input  logic                    areset,
  mem_subblock_wrapper_core_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_cnt,
  output logic [AW-1:0]           first_err_addr,
  output logic [2:0]              fsm_state
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]    state;
  logic [AW-1:0] addr;
  logic          last;
  logic          aw_fire;
  logic          b_fire;
  logic          ar_fire;
  logic          r_fire;
  logic          err_evt;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [AW-1:0] a);
    logic [7:0] b;
    b = 8'(a);
    return {(DATA_WIDTH/8){b}} ^ DATA_WIDTH'(SEED);
  endfunction

  assign last    = (addr == AW'(DEPTH - 1));
  assign aw_fire = bus.awvalid && bus.awready && bus.wvalid && bus.wready;
  assign b_fire  = bus.bvalid && bus.bready;
  assign ar_fire = bus.arvalid && bus.arready;
  assign r_fire  = bus.rvalid && bus.rready;

  // An error response counts like a data mismatch at the current address.
  assign err_evt = (state == WR_RESP && b_fire && bus.bresp != 2'b00) ||
                   (state == RD_DATA && r_fire &&
                    (bus.rdata != pattern(addr) || bus.rresp != 2'b00));

  // Request valids come straight from the state register, so they stay up
  // with a stable address/data until the slave accepts them.
  assign bus.awvalid = (state == WR_REQ) && !areset;
  assign bus.wvalid  = (state == WR_REQ) && !areset;
  assign bus.awaddr  = addr;
  assign bus.wdata   = pattern(addr);
  assign bus.arvalid = (state == RD_REQ) && !areset;
  assign bus.araddr  = addr;
  assign bus.bready  = 1'b1;
  assign bus.rready  = 1'b1;

  assign busy      = !areset && (state == WR_REQ || state == WR_RESP ||
                                 state == RD_REQ || state == RD_DATA);
  assign done      = !areset && (state == DONE);
  assign pass      = done && (err_cnt == 16'd0);
  assign fsm_state = state;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      addr           <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      if (err_evt) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0)    first_err_addr <= addr;
      end
      case (state)
        IDLE:    state <= WR_REQ;
        WR_REQ:  if (aw_fire) state <= WR_RESP;
        WR_RESP: if (b_fire) begin
          addr  <= addr + AW'(1);
          state <= last ? RD_REQ : WR_REQ;
        end
        RD_REQ:  if (ar_fire) state <= RD_DATA;
        RD_DATA: if (r_fire) begin
          addr  <= addr + AW'(1);
          state <= last ? DONE : RD_REQ;
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module mem_subblock_slave #(
  parameter int  DEPTH      = 256,
  parameter int  DATA_WIDTH = 32,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic aclk,
  input  logic areset,
  input  logic fault_inject,
  mem_subblock_wrapper_core_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  bvalid_q;
  logic                  rvalid_q;
  logic                  idle;
  logic                  wr_fire;
  logic                  rd_fire;

  assign idle    = !bvalid_q && !rvalid_q && !areset;
  assign wr_fire = idle && bus.awvalid && bus.wvalid;
  assign rd_fire = bus.arvalid && bus.arready;

  // AW and W are only taken together; arready drops only when a complete
  // write competes for the single RAM port in the same cycle.
  assign bus.awready = idle;
  assign bus.wready  = idle;
  assign bus.arready = idle && !(bus.awvalid && bus.wvalid);

  assign bus.bvalid = bvalid_q && !areset;
  assign bus.bresp  = 2'b00;
  assign bus.rvalid = rvalid_q && !areset;
  assign bus.rresp  = 2'b00;
  assign bus.rdata  = rdata_q ^ DATA_WIDTH'(fault_inject && rvalid_q);

  // RAM array and read register carry no reset so contents survive areset.
  always_ff @(posedge aclk) begin
    if (wr_fire) mem[bus.awaddr] <= bus.wdata;
    if (rd_fire) rdata_q <= mem[bus.araddr];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
      if (wr_fire)                bvalid_q <= 1'b1;
      if (rvalid_q && bus.rready) rvalid_q <= 1'b0;
      if (rd_fire)                rvalid_q <= 1'b1;
    end
  end
endmodule

module mem_subblock_wrapper_core #(
  parameter int          DEPTH      = 256,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'hA5A5A5A5,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          fault_inject,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic [2:0]    fsm_state
);
  mem_subblock_wrapper_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DATA_WIDTH)) link ();

  mem_subblock_master #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_master (
    .aclk           (aclk),
    .areset         (areset),
    .bus            (link),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .fsm_state      (fsm_state)
  );

  mem_subblock_slave #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_slave (
    .aclk         (aclk),
    .areset       (areset),
    .fault_inject (fault_inject),
    .bus          (link)
  );
endmodule

// File: tb/tb_mem_subblock_wrapper_core.sv
// Bench for the memory self-test wrapper: directed and randomized fault scenarios against a cycle-schedule model.
module tb_mem_subblock_wrapper_core;
  localparam int          DEPTH = 256;
  localparam int          DW    = 32;
  localparam int          AW    = 8;
  localparam logic [31:0] SEED  = 32'hA5A5A5A5;
  localparam int          DONE_CYC = 4 * DEPTH + 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          fault_inject = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [2:0]    fsm_state;

  int errors = 0;
  int checks = 0;
  bit flt_addr [DEPTH];

  always #5 aclk = ~aclk;

  mem_subblock_wrapper_core #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SEED(SEED)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .fault_inject   (fault_inject),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .fsm_state      (fsm_state)
  );

  mem_subblock_wrapper_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mon ();
  assign mon.awvalid = dut.link.awvalid;
  assign mon.awready = dut.link.awready;
  assign mon.awaddr  = dut.link.awaddr;
  assign mon.wvalid  = dut.link.wvalid;
  assign mon.wready  = dut.link.wready;
  assign mon.wdata   = dut.link.wdata;
  assign mon.bvalid  = dut.link.bvalid;
  assign mon.bready  = dut.link.bready;
  assign mon.bresp   = dut.link.bresp;
  assign mon.arvalid = dut.link.arvalid;
  assign mon.arready = dut.link.arready;
  assign mon.araddr  = dut.link.araddr;
  assign mon.rvalid  = dut.link.rvalid;
  assign mon.rready  = dut.link.rready;
  assign mon.rdata   = dut.link.rdata;
  assign mon.rresp   = dut.link.rresp;

  // Protocol watcher: responses exactly one cycle after the request
  // handshake, pending valids held stable, never two transactions in flight.
  logic          prev_aw_fire = 1'b0, prev_ar_fire = 1'b0;
  logic          pend_aw = 1'b0, pend_ar = 1'b0;
  logic [AW-1:0] pend_awaddr = '0, pend_araddr = '0;
  int            viol = 0;
  always @(posedge aclk) begin
    if (areset) begin
      prev_aw_fire <= 1'b0;
      prev_ar_fire <= 1'b0;
      pend_aw      <= 1'b0;
      pend_ar      <= 1'b0;
    end else begin
      if ((mon.bvalid !== prev_aw_fire) || (mon.rvalid !== prev_ar_fire) ||
          (mon.bready !== 1'b1) || (mon.rready !== 1'b1) ||
          (pend_aw && !(mon.awvalid && mon.wvalid && mon.awaddr == pend_awaddr)) ||
          (pend_ar && !(mon.arvalid && mon.araddr == pend_araddr)) ||
          ((mon.awvalid || mon.arvalid) && (mon.bvalid || mon.rvalid)) ||
          (mon.awvalid && mon.arvalid) ||
          (mon.bvalid && mon.bresp !== 2'b00) || (mon.rvalid && mon.rresp !== 2'b00))
        viol <= viol + 1;
      prev_aw_fire <= mon.awvalid && mon.wvalid && mon.awready && mon.wready;
      prev_ar_fire <= mon.arvalid && mon.arready;
      pend_aw      <= mon.awvalid && !(mon.awready && mon.wready);
      pend_ar      <= mon.arvalid && !mon.arready;
      pend_awaddr  <= mon.awaddr;
      pend_araddr  <= mon.araddr;
    end
  end

  function automatic logic [DW-1:0] exp_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {(DW/8){b}} ^ SEED;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    areset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".pass"}, 32'(pass), 32'd0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, ".first_err_addr"}, 32'(first_err_addr), 32'd0);
    check({tag, ".valids"}, {28'd0, mon.awvalid, mon.wvalid, mon.arvalid, mon.bvalid | mon.rvalid}, 32'd0);
  endtask

  // Releases reset and runs one full sequence. Cycle c is the c-th cycle after
  // release; the R beat of address a falls in cycle 2*DEPTH+2+2a.
  task automatic run_seq(input bit hold, input bit noise, input bit mem_chk, input string tag);
    int  exp_err, exp_first, done_cyc, bad, ra;
    bit  f, rbeat;
    exp_err = 0; exp_first = 0; done_cyc = -1; bad = 0;
    areset = 1'b0;
    for (int c = 0; c <= DONE_CYC; c++) begin
      rbeat = (c >= 2*DEPTH + 2) && (c <= 4*DEPTH) && (((c - 2*DEPTH - 2) % 2) == 0);
      ra    = (c - 2*DEPTH - 2) / 2;
      f     = hold ? 1'b1 : (noise ? ($urandom_range(0, 3) == 0) : 1'b0);
      if (rbeat && !hold) f = flt_addr[ra];
      fault_inject = f;
      if (rbeat && f) begin
        if (exp_err == 0) exp_first = ra;
        exp_err++;
      end
      if (busy !== ((c >= 1) && (c <= 4*DEPTH))) bad++;
      if (done !== (c >= DONE_CYC)) bad++;
      if (done_cyc < 0 && done === 1'b1) done_cyc = c;
      if (mem_chk && c == 600) begin
        int r;
        r = $urandom_range(0, DEPTH - 1);
        check({tag, ".mem0"}, dut.u_slave.mem[0], 32'hA5A5A5A5);
        check({tag, ".mem1"}, dut.u_slave.mem[1], 32'hA4A4A4A4);
        check({tag, ".mem255"}, dut.u_slave.mem[255], 32'h5A5A5A5A);
        check({tag, ".mem_rand"}, dut.u_slave.mem[r], exp_word(r));
      end
      if (c < DONE_CYC) @(negedge aclk);
    end
    fault_inject = 1'b0;
    check({tag, ".done_cycle"}, 32'(done_cyc), 32'(DONE_CYC));
    check({tag, ".busy_done_trace"}, 32'(bad), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".pass"}, 32'(pass), 32'(exp_err == 0));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check({tag, ".first_err_addr"}, 32'(first_err_addr), 32'(exp_first));
    check({tag, ".protocol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    foreach (flt_addr[i]) flt_addr[i] = 1'b0;

    do_reset("reset0");
    run_seq(1'b0, 1'b0, 1'b1, "clean");

    do_reset("reset1");
    flt_addr[7] = 1'b1;
    run_seq(1'b0, 1'b0, 1'b0, "fault7");
    flt_addr[7] = 1'b0;

    do_reset("reset2");
    run_seq(1'b1, 1'b0, 1'b0, "hold");

    // Reset pulsed for one cycle in the middle of the write phase.
    do_reset("reset3");
    areset = 1'b0;
    repeat (300) @(negedge aclk);
    check("abort.busy_before", 32'(busy), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.err_cnt", 32'(err_cnt), 32'd0);
    check("abort.valids", {30'd0, mon.awvalid, mon.bvalid}, 32'd0);
    check("abort.ram_kept", dut.u_slave.mem[200], exp_word(200));
    run_seq(1'b0, 1'b0, 1'b0, "abort_rerun");

    do_reset("reset4");
    begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) flt_addr[$urandom_range(0, DEPTH - 1)] = 1'b1;
    end
    run_seq(1'b0, 1'b1, 1'b0, "random");

    do_reset("reset5");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_subblock_wrapper_core.md
MEM_SUBBLOCK_WRAPPER_CORE -- requirements
Module: mem_subblock_wrapper

Interface
REQ-001 Parameter DEPTH, default 256: number of memory words; power of two, 4..4096.
REQ-002 Parameter DATA_WIDTH, default 32: memory word width; multiple of 8.
REQ-003 Parameter SEED, default 32'hA5A5A5A5: XOR mask applied to the test pattern; truncated to DATA_WIDTH.
REQ-004 aclk  input  1  single clock; all logic on the rising edge.
REQ-005 areset  input  1  reset; synchronous and active-high.
REQ-006 fault_inject  input  1  when high during a read-data beat, the slave inverts bit 0 of the returned data.
REQ-007 busy  output  1  high while the self-test sequence runs.
REQ-008 done  output  1  high once the sequence completes; held until reset.
REQ-009 pass  output  1  valid when done=1; 1 means zero mismatches.
REQ-010 err_cnt  output  16  mismatch count; saturates at 16'hFFFF.
REQ-011 first_err_addr  output  log2(DEPTH)  address of the first mismatch; 0 if none.

Function
REQ-012 Internal structure: a traffic-generator master and a single-port RAM slave (DEPTH x DATA_WIDTH) joined by a simplified AXI4-Lite link (AW/W/B/AR/R channels with valid/ready).
REQ-013 Handshake: a transfer occurs in a cycle where valid and ready are both high; valid, once asserted, holds with stable payload until accepted.
REQ-014 The slave holds awready/wready/arready high whenever it is idle; it accepts AW and W only together in the same cycle.
REQ-015 The slave asserts bvalid the cycle after the write is accepted, with bresp=OKAY.
REQ-016 The slave asserts rvalid the cycle after AR is accepted, with rresp=OKAY. Read latency is 1 cycle.
REQ-017 The master holds bready and rready high at all times.
REQ-018 Pattern for address a: data(a) = {DATA_WIDTH/8 copies of a[7:0]} XOR SEED.
REQ-019 Master FSM states and transitions:
- IDLE: 1 cycle -> WR_REQ.
- WR_REQ: AW+W handshake -> WR_RESP.
- WR_RESP: B handshake; last address -> RD_REQ, else address+1 -> WR_REQ.
- RD_REQ: AR handshake -> RD_DATA.
- RD_DATA: R handshake and compare; last address -> DONE, else address+1 -> RD_REQ.
- DONE: terminal until reset.
REQ-020 Addresses run 0..DEPTH-1 in both phases; the address counter wraps to 0 between phases.
REQ-021 Each write and each read takes exactly 2 cycles. With cycle 0 being the first cycle with areset low, done rises in cycle 4*DEPTH+1 (1025 for DEPTH=256).
REQ-022 On each R beat, if rdata != data(addr): err_cnt increments (saturating), and first_err_addr is loaded if err_cnt was 0.
REQ-023 busy = 1 in WR_REQ, WR_RESP, RD_REQ and RD_DATA states only. done = 1 in DONE only. pass = done AND (err_cnt==0).
REQ-024 A non-OKAY bresp or rresp counts as one mismatch. This cannot occur with the specified slave, but the logic is required.
REQ-025 A fault_inject change takes effect only on the R beat of the cycle in which it is sampled high.

Reset
REQ-026 While areset=1: FSM=IDLE, address=0, all valid signals=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0.
REQ-027 RAM contents are not cleared by reset.
REQ-028 Reset asserted mid-sequence aborts any in-flight transfer without a handshake; after release the full sequence restarts from address 0.

Verification
REQ-029 Reset 2 cycles, then release, fault_inject=0 -> busy=1 from cycle 1; done=1 and pass=1 at cycle 1025; err_cnt=0.
REQ-030 Memory inspection after the write phase -> word 0=0xA5A5A5A5, word 1=0xA4A4A4A4, word 255=0x5A5A5A5A.
REQ-031 fault_inject pulsed high for exactly the R beat of address 7 -> done with pass=0, err_cnt=1, first_err_addr=7.
REQ-032 fault_inject held high for the whole run -> err_cnt=256, first_err_addr=0, pass=0.
REQ-033 areset asserted at cycle 300 for 1 cycle -> all outputs return to their reset values; done rises 1025 cycles after release with pass=1.
REQ-034 Protocol checks every cycle -> no valid drops before its handshake; no more than one outstanding transaction; bvalid/rvalid appear exactly 1 cycle after the request handshake.
